// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter.
package wb_pkg;
    localparam int NREGS = 16;
    localparam logic [3:0] RSP_IDX = 4'd4;
    localparam logic [63:0] RSP_STEP = 64'd8;
    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_INC  = 2'b01,
        RSP_DEC  = 2'b10
    } rsp_op_t;
    typedef logic [1:0] wb_state_t;
    localparam wb_state_t IDLE   = 2'd0;
    localparam wb_state_t SECOND = 2'd1;
    localparam wb_state_t HALTED = 2'd2;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write mask, a set beats a clear on the same register.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [3:0]       set_idx,
    input  logic             clr_en,
    input  logic [3:0]       clr_idx,
    input  logic             clr_rsp,
    output logic [NREGS-1:0] busy
);
    logic [NREGS-1:0] set_m, clr_m;
    assign set_m = {{(NREGS-1){1'b0}}, set_en} << set_idx;
    assign clr_m = ({{(NREGS-1){1'b0}}, clr_en} << clr_idx) | ({{(NREGS-1){1'b0}}, clr_rsp} << RSP_IDX);
    always_ff @(posedge clk) begin
        busy <= reset ? '0 : (busy & ~clr_m) | set_m;
    end
endmodule

// File: rtl/mod_wb_arbiter.sv
// mod_wb_arbiter: round-robin writeback arbiter/sequencer; busy scoreboard built only with WB_SCOREBOARD_EN.
module mod_wb_arbiter
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [3:0]       ex_dst0,
    input  logic [3:0]       ex_dst1,
    input  logic [63:0]      ex_data0,
    input  logic [63:0]      ex_data1,
    input  logic             ex_dual,
    input  logic [1:0]       ex_rsp_op,
    input  logic             ex_nowrite,
    input  logic             ex_sim_end,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [3:0]       mem_dst,
    input  logic [63:0]      mem_data,
    input  logic [63:0]      rsp_in,
    output logic             rf_we,
    output logic [3:0]       rf_waddr,
    output logic [63:0]      rf_wdata,
    output logic             rf_rsp_we,
    output logic [63:0]      rf_rsp_wdata,
    input  logic             rsv_valid,
    input  logic [3:0]       rsv_dst,
    output logic [NREGS-1:0] busy,
    output logic             halt
);
    wb_state_t state;
    logic prio_ex, end_pend, idle, grant_ex, grant_mem, data_wr, rsp_act;
    logic [3:0] dst1_q;
    logic [63:0] data1_q;
    rsp_op_t op;
    assign op = rsp_op_t'(ex_rsp_op);
    assign idle = state == IDLE && !reset;
    assign grant_ex = idle && ex_valid && (!mem_valid || prio_ex);
    assign grant_mem = idle && mem_valid && !grant_ex;
    assign ex_ready = grant_ex;
    assign mem_ready = grant_mem;
    assign data_wr = !ex_nowrite;
    assign rsp_act = op == RSP_INC || op == RSP_DEC;
    // prio_ex only moves on contention, so an uncontested grant does not steal the next turn
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            prio_ex <= 1'b0;
            end_pend <= 1'b0;
            dst1_q <= '0;
            data1_q <= '0;
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_rsp_we <= 1'b0;
            rf_rsp_wdata <= '0;
            halt <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            rf_rsp_we <= 1'b0;
            halt <= state == HALTED;
            if (ex_valid && mem_valid && idle) prio_ex <= grant_mem;
            if (state == SECOND) begin
                rf_we <= 1'b1;
                rf_waddr <= dst1_q;
                rf_wdata <= data1_q;
                state <= end_pend ? HALTED : IDLE;
            end else if (grant_mem) begin
                rf_we <= 1'b1;
                rf_waddr <= mem_dst;
                rf_wdata <= mem_data;
            end else if (grant_ex) begin
                rf_we <= data_wr;
                rf_waddr <= ex_dst0;
                rf_wdata <= ex_data0;
                dst1_q <= ex_dst1;
                data1_q <= ex_data1;
                end_pend <= ex_sim_end;
                rf_rsp_we <= rsp_act && !(data_wr && ex_dst0 == RSP_IDX);
                if (rsp_act) rf_rsp_wdata <= op == RSP_INC ? rsp_in + RSP_STEP : rsp_in - RSP_STEP;
                state <= data_wr && ex_dual ? SECOND : ex_sim_end ? HALTED : IDLE;
            end
        end
    end
`ifdef WB_SCOREBOARD_EN
    wb_scoreboard u_sb (
        .clk(clk),
        .reset(reset),
        .set_en(rsv_valid),
        .set_idx(rsv_dst),
        .clr_en(rf_we),
        .clr_idx(rf_waddr),
        .clr_rsp(rf_rsp_we),
        .busy(busy)
    );
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_dst};
    assign busy = '0;
`endif
endmodule

// File: tb/tb_mod_wb_arbiter.sv
// tb_mod_wb_arbiter: directed bench with a queue-based writeback model checked every cycle.
module tb_mod_wb_arbiter;
    logic clk, reset;
    logic ex_valid, ex_ready, ex_dual, ex_nowrite, ex_sim_end;
    logic [3:0] ex_dst0, ex_dst1, mem_dst, rf_waddr, rsv_dst;
    logic [63:0] ex_data0, ex_data1, mem_data, rsp_in, rf_wdata, rf_rsp_wdata;
    logic [1:0] ex_rsp_op;
    logic mem_valid, mem_ready, rf_we, rf_rsp_we, rsv_valid, halt;
    logic [15:0] busy;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif
    int n_chk = 0;
    int n_err = 0;

    mod_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_dst0(ex_dst0), .ex_dst1(ex_dst1), .ex_data0(ex_data0), .ex_data1(ex_data1),
        .ex_dual(ex_dual), .ex_rsp_op(ex_rsp_op), .ex_nowrite(ex_nowrite), .ex_sim_end(ex_sim_end),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
        .rsp_in(rsp_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_rsp_we(rf_rsp_we), .rf_rsp_wdata(rf_rsp_wdata),
        .rsv_valid(rsv_valid), .rsv_dst(rsv_dst),
        .busy(busy), .halt(halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: expected registered outputs plus a queue of writes still owed
    bit m_init = 0;
    bit m_prio_ex, m_stop, m_end;
    logic [67:0] m_q[$];
    logic e_we, e_rsp_we, e_halt;
    logic [3:0] e_waddr;
    logic [63:0] e_wdata, e_rsp_wdata;
    logic [15:0] e_busy;

    always @(posedge clk) begin
        logic [15:0] nb;
        logic [67:0] w;
        bit gx, gm;
        if (reset) begin
            m_init = 1; m_prio_ex = 0; m_stop = 0; m_end = 0; m_q.delete();
            e_we = 0; e_rsp_we = 0; e_halt = 0; e_waddr = 0; e_wdata = 0; e_rsp_wdata = 0; e_busy = 0;
        end else if (m_init) begin
            nb = e_busy;
            if (e_we) nb[e_waddr] = 1'b0;
            if (e_rsp_we) nb[4] = 1'b0;
            if (rsv_valid) nb[rsv_dst] = 1'b1;
            e_busy = SB ? nb : 16'h0;
            e_halt = e_halt | m_stop;
            e_we = 0;
            e_rsp_we = 0;
            if (m_q.size() > 0) begin
                w = m_q.pop_front();
                e_we = 1; e_waddr = w[67:64]; e_wdata = w[63:0];
                if (m_end) m_stop = 1;
            end else if (!m_stop) begin
                gx = ex_valid && (!mem_valid || m_prio_ex);
                gm = mem_valid && !gx;
                if (ex_valid && mem_valid) m_prio_ex = gm;
                if (gm) begin
                    e_we = 1; e_waddr = mem_dst; e_wdata = mem_data;
                end
                if (gx) begin
                    if (!ex_nowrite) begin
                        e_we = 1; e_waddr = ex_dst0; e_wdata = ex_data0;
                        if (ex_dual) m_q.push_back({ex_dst1, ex_data1});
                    end
                    if (ex_rsp_op == 2'b01 || ex_rsp_op == 2'b10) begin
                        e_rsp_wdata = ex_rsp_op == 2'b01 ? rsp_in + 64'd8 : rsp_in - 64'd8;
                        e_rsp_we = ex_nowrite || ex_dst0 != 4'd4;
                    end
                    if (ex_sim_end) begin
                        if (m_q.size() > 0) m_end = 1;
                        else m_stop = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit idle_m, x_ex, x_mem;
        if (m_init) begin
            idle_m = !reset && m_q.size() == 0 && !m_stop;
            x_ex = idle_m && ex_valid && (!mem_valid || m_prio_ex);
            x_mem = idle_m && mem_valid && !x_ex;
            chk("m_ex_ready", ex_ready, x_ex);
            chk("m_mem_ready", mem_ready, x_mem);
            chk("m_rf_we", rf_we, e_we);
            if (e_we) begin
                chk("m_rf_waddr", rf_waddr, e_waddr);
                chk("m_rf_wdata", rf_wdata, e_wdata);
            end
            chk("m_rsp_we", rf_rsp_we, e_rsp_we);
            if (e_rsp_we) chk("m_rsp_wdata", rf_rsp_wdata, e_rsp_wdata);
            chk("m_busy", busy, e_busy);
            chk("m_halt", halt, e_halt);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        ex_valid = 0; mem_valid = 0; ex_dual = 0; ex_nowrite = 0; ex_sim_end = 0;
        ex_rsp_op = 0; rsv_valid = 0;
    endtask

    task automatic ex_req(input logic [3:0] d0, input logic [63:0] x0, input logic [3:0] d1,
                          input logic [63:0] x1, input logic dual, input logic [1:0] op,
                          input logic nw, input logic se);
        ex_valid = 1; ex_dst0 = d0; ex_data0 = x0; ex_dst1 = d1; ex_data1 = x1;
        ex_dual = dual; ex_rsp_op = op; ex_nowrite = nw; ex_sim_end = se;
    endtask

    task automatic mem_req(input logic [3:0] d, input logic [63:0] x);
        mem_valid = 1; mem_dst = d; mem_data = x;
    endtask

    initial begin
        idle_in();
        ex_dst0 = 0; ex_dst1 = 0; ex_data0 = 0; ex_data1 = 0; mem_dst = 0; mem_data = 0;
        rsp_in = 0; rsv_dst = 0;
        reset = 1;
        step(); step();
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_rsp_we", rf_rsp_we, 0);
        chk("rst_rsp_wdata", rf_rsp_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halt", halt, 0);
        ex_req(3, 64'hAA, 0, 0, 0, 0, 0, 0);
        mem_req(5, 64'hBB);
        #1 chk("rst_ex_ready", ex_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        reset = 0;
        #1 chk("rr_first_mem", mem_ready, 1);
        chk("rr_first_ex", ex_ready, 0);
        step();
        chk("rr_w1_addr", rf_waddr, 5);
        chk("rr_w1_data", rf_wdata, 64'hBB);
        mem_valid = 0;
        #1 chk("rr_ex_ready", ex_ready, 1);
        step();
        chk("rr_w2_addr", rf_waddr, 3);
        chk("rr_w2_data", rf_wdata, 64'hAA);
        ex_req(1, 64'h11, 0, 0, 0, 0, 0, 0);
        mem_req(6, 64'h66);
        #1 chk("rr_second_ex", ex_ready, 1);
        step();
        chk("rr_w3_addr", rf_waddr, 1);
        ex_valid = 0;
        step();
        chk("rr_w4_addr", rf_waddr, 6);
        mem_valid = 0;
        ex_req(0, 64'h10, 2, 64'h20, 1, 0, 0, 0);
        step();
        chk("dual_w1", {rf_waddr, rf_wdata}, {4'd0, 64'h10});
        ex_valid = 0;
        mem_req(9, 64'h99);
        #1 chk("dual_mem_ready_low", mem_ready, 0);
        step();
        chk("dual_w2_we", rf_we, 1);
        chk("dual_w2", {rf_waddr, rf_wdata}, {4'd2, 64'h20});
        #1 chk("dual_mem_ready_back", mem_ready, 1);
        step();
        chk("dual_mem_addr", rf_waddr, 9);
        mem_valid = 0;
        rsp_in = 64'h1000;
        ex_req(3, 0, 0, 0, 0, 2'b10, 1, 0);
        step();
        chk("push_rsp_we", rf_rsp_we, 1);
        chk("push_rsp_data", rf_rsp_wdata, 64'hFF8);
        chk("push_no_we", rf_we, 0);
        rsp_in = 0;
        step();
        chk("push_wrap", rf_rsp_wdata, 64'hFFFF_FFFF_FFFF_FFF8);
        rsp_in = 64'h2000;
        ex_req(4, 64'h500, 0, 0, 0, 2'b01, 0, 0);
        step();
        chk("pop_rsp_we", rf_rsp_we, 0);
        chk("pop_we", {rf_we, rf_waddr, rf_wdata}, {1'b1, 4'd4, 64'h500});
        ex_req(3, 0, 0, 0, 1, 2'b11, 1, 0);
        step();
        chk("rsvd_op", {rf_we, rf_rsp_we}, 0);
        ex_req(11, 64'hB0, 0, 0, 0, 2'b01, 0, 0);
        step();
        chk("inc_both", {rf_we, rf_rsp_we}, 2'b11);
        chk("inc_data", rf_rsp_wdata, 64'h2008);
        rsv_valid = 1; rsv_dst = 4;
        ex_req(7, 64'h77, 0, 0, 0, 0, 0, 0);
        step();
        chk("sb_rsp_set", busy[4], SB);
        ex_valid = 0;
        rsv_dst = 7;
        step();
        chk("sb_set_wins", busy[7], SB);
        rsv_valid = 0;
        ex_req(7, 64'h78, 0, 0, 0, 0, 0, 0);
        step();
        ex_req(0, 0, 0, 0, 0, 2'b01, 1, 0);
        step();
        chk("sb_clear7", busy[7], 0);
        chk("sb_keep4", busy[4], SB);
        ex_valid = 0;
        step();
        chk("sb_rsp_clear", busy, 0);
        ex_req(8, 64'h88, 9, 64'h99, 1, 0, 0, 1);
        step();
        chk("end_w1", rf_waddr, 8);
        mem_req(10, 64'hA0);
        #1 chk("end_ready_sec", {ex_ready, mem_ready}, 0);
        step();
        chk("end_w2", {rf_we, rf_waddr}, {1'b1, 4'd9});
        chk("end_halt_low", halt, 0);
        step();
        chk("end_halt_rise", halt, 1);
        chk("end_no_we", rf_we, 0);
        step(); step();
        chk("end_halt_sticky", halt, 1);
        chk("end_ready_halt", {ex_ready, mem_ready}, 0);
        reset = 1;
        idle_in();
        step();
        chk("rst2_halt", halt, 0);
        reset = 0;
        ex_req(12, 64'hC, 13, 64'hD, 1, 0, 0, 0);
        step();
        chk("mid_w1", rf_waddr, 12);
        ex_valid = 0;
        reset = 1;
        step();
        chk("mid_rst_we", rf_we, 0);
        reset = 0;
        step();
        chk("mid_dropped", rf_we, 0);
        ex_req(14, 64'hE, 0, 0, 0, 0, 0, 0);
        #1 chk("mid_idle_ready", ex_ready, 1);
        step();
        chk("mid_after", {rf_we, rf_waddr}, {1'b1, 4'd14});
        idle_in();
        step(); step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mod_wb_arbiter.md
# mod_wb_arbiter

Writeback arbiter and sequencer for the 16 x 64-bit architectural register file. It accepts retire requests from the execute path (ALU results, including dual-destination multiply/divide and RSP-adjusting push/pop/call/ret) and from the memory path (load results), and grants one per cycle. It drives the single registered data write port plus the dedicated RSP update port, and keeps the per-register pending scoreboard that issue logic reads to stall.

## Interface
Parameters:
- NREGS, 16, architectural register count; fixed at 16.
- RSP_IDX, 4, index of RSP.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- ex_valid / ex_ready  in / out  1 / 1  execute request handshake
- ex_dst0, ex_dst1  in  4 each  destination registers
- ex_data0, ex_data1  in  64 each  write data
- ex_dual  in  1  second write (dst1/data1) required
- ex_rsp_op  in  2  00 none, 01 RSP+8, 10 RSP-8, 11 reserved (treated as none)
- ex_nowrite  in  1  no data write (store, push, call); RSP op still applies
- ex_sim_end  in  1  last instruction of the program
- mem_valid / mem_ready  in / out  1 / 1  load request handshake
- mem_dst  in  4; mem_data  in  64  load destination and data
- rsp_in  in  64  current RSP value from the register file
- rf_we  out  1; rf_waddr  out  4; rf_wdata  out  64  data write port
- rf_rsp_we  out  1; rf_rsp_wdata  out  64  RSP update port
- rsv_valid  in  1; rsv_dst  in  4  issue-stage destination reservation
- busy  out  16  pending-write mask, bit i = register i
- halt  out  1  sticky end-of-simulation flag

## Operation
- FSM states: IDLE, SECOND, HALTED.
- IDLE: a requester is granted when valid. If both are valid, the grant is round-robin: the requester not granted last wins. After reset the pointer favours mem.
- ex_ready and mem_ready are combinational: high only for the granted requester in IDLE. Both are low in SECOND and HALTED.
- On ex accept with ex_dual=1, the FSM goes to SECOND. dst1/data1 are latched at accept. SECOND emits the second write, then returns to IDLE.
- On accept with ex_sim_end=1, the FSM enters HALTED after its final write. halt=1 holds until reset. No further grants.
- RSP: at accept, rf_rsp_wdata = rsp_in +8 or -8, modulo 2^64 (wraps silently).
  - If the same accept also writes dst0=RSP_IDX with ex_nowrite=0, the data write wins and rf_rsp_we is suppressed (POP RSP semantics).
  - Reserved code 11 produces no RSP write.
- ex_nowrite=1: rf_we stays 0 for that request, and ex_dual is ignored.
- Scoreboard:
  - rsv_valid sets busy[rsv_dst].
  - A cycle with rf_we=1 clears busy[rf_waddr].
  - If set and clear hit the same register in one cycle, the set wins.
  - An RSP-port update also clears busy[RSP_IDX].

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, rf_rsp_we=0, rf_rsp_wdata=0, busy=0, halt=0, ex_ready=0, mem_ready=0. FSM=IDLE, pointer=mem.
- Latency: accept on edge t puts the first write on the outputs during cycle t+1. The dual second write appears in cycle t+2. The RSP write appears in t+1.
- Throughput: one single-write request per cycle. A dual request costs 2 cycles.
- busy reflects sets and clears one cycle after the causing event.
- Reset mid-SECOND: the pending second write is dropped, and no write is asserted in the cycle after reset.
- Requesters must hold valid and payload stable until ready.

## Configuration
- WB_SCOREBOARD_EN defined: the scoreboard is implemented as above.
- WB_SCOREBOARD_EN undefined: busy is tied to 0, rsv_valid and rsv_dst are ignored, and no scoreboard flops are instantiated.

## Structure
- Shared package wb_pkg holds:
  - typedef rsp_op_t (2-bit enum RSP_NONE/RSP_INC/RSP_DEC)
  - typedef wb_state_t
  - constants RSP_IDX, NREGS, RSP_STEP=8
- One natural sub-module, wb_scoreboard: the 16-bit set/clear mask with set-over-clear priority. It is instantiated only under WB_SCOREBOARD_EN.

## Test plan
- ex and mem valid together after reset, ex dst0=3/data 0xAA, mem dst=5/data 0xBB -> mem granted first (rf_waddr=5 in t+1), ex next cycle (rf_waddr=3). On the next contention, ex wins.
- ex_dual, dst0=0/data 0x10, dst1=2/data 0x20 -> writes 0 then 2 in consecutive cycles; both readies low during SECOND.
- ex_rsp_op=10, ex_nowrite=1, rsp_in=0x1000 -> rf_rsp_we with 0xFF8, rf_we=0. rsp_in=0 with op 10 -> 0xFFFF_FFFF_FFFF_FFF8.
- ex_rsp_op=01, dst0=4, data 0x500 -> rf_we to reg 4 with 0x500, rf_rsp_we=0.
- rsv_valid dst=7 the same cycle a write to 7 retires -> busy[7] stays 1. The next write to 7 clears it. With the macro off, busy stays 0.
- ex_sim_end on a dual request -> halt rises after the second write, readies stay low. Reset -> halt=0, FSM IDLE.
